// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N shift-add multiplier.
// Each RUN cycle adds the multiplicand into the upper accumulator when the
// current multiplier LSB is set. It keeps the carry-out of that N-bit add and
// shifts {carry, acc_hi, mq} right by one. After N iterations the 2N-bit
// product is {acc_hi, mq}.
//
// Handshake (start/busy/done):
//   - start is sampled only in IDLE; a high start on a rising edge captures a/b.
//   - busy is high for exactly the N RUN cycles that follow the accepting edge.
//   - done is a one-cycle pulse in DONE; product is valid from that cycle on.
//   - product holds until the next DONE entry or reset.
//   - start seen during RUN/DONE is ignored.
module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [1:0]     dbg_state
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [N-1:0]  mcand;
  logic [N-1:0]  acc_hi;
  logic [N-1:0]  mq;
  logic [CW-1:0] count;

  logic [N:0]    sum;
  logic [N-1:0]  acc_hi_next;
  logic [N-1:0]  mq_next;
  logic          last_iter;

  // Partial add plus the one-bit right shift; the carry-out becomes acc_hi's MSB.
  always_comb begin
    sum         = {1'b0, acc_hi} + (mq[0] ? {1'b0, mcand} : {(N+1){1'b0}});
    acc_hi_next = sum[N:1];
    mq_next     = {sum[0], mq[N-1:1]};
    last_iter   = (count == CW'(N - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      acc_hi  <= '0;
      mq      <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mq     <= b;
            acc_hi <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc_hi <= acc_hi_next;
          mq     <= mq_next;
          count  <= count + CW'(1);
          if (last_iter) product <= {acc_hi_next, mq_next};
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
